// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch unit. Issues one instruction-memory read at a time,
//   buffers returned words in a small FIFO, and presents them to decode with a
//   valid/ready handshake. Redirects from execute flush the buffer and restart
//   fetching at the new target. Any response still in flight when a redirect
//   lands is dropped.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : asynchronous, active-high reset
//   mem_req_valid  : read request to instruction memory
//   mem_req_addr   : request byte address (word aligned)
//   mem_req_ready  : memory accepts the request this cycle
//   mem_rsp_valid  : response word present
//   mem_rsp_data   : instruction word
//   mem_rsp_err    : access fault on the response
//   redirect_valid : control-flow redirect from execute
//   redirect_pc    : redirect target (low two bits ignored)
//   halt           : stop starting new requests from IDLE
//   out_valid      : buffered instruction available to decode
//   out_addr       : PC of the instruction on the output
//   out_instr      : instruction word on the output
//   out_fault      : access fault flag for that entry
//   out_ready      : decode consumes the entry this cycle
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  output logic [63:0] out_addr,
  output logic [31:0] out_instr,
  output logic        out_fault,
  input  logic        out_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [63:0]       r_fetch_pc;
  logic [63:0]       r_req_pc;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [63:0]       r_mem_addr  [FIFO_DEPTH];
  logic [31:0]       r_mem_instr [FIFO_DEPTH];
  logic              r_mem_fault [FIFO_DEPTH];

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_out_valid;
  logic [CNT_W-1:0]  w_count_after;
  logic [63:0]       w_redirect_aligned;

  assign w_redirect_aligned = redirect_pc & ~64'h3;
  assign w_out_valid        = (r_count != '0);
  assign w_accept           = (r_state == ST_REQ) && mem_req_ready;
  // Responses are only buffered in WAIT; a same-cycle redirect makes them stale.
  assign w_push             = (r_state == ST_WAIT) && mem_rsp_valid && !redirect_valid;
  // A redirect flushes the buffer, so a pop in that cycle is meaningless.
  assign w_pop              = w_out_valid && out_ready && !redirect_valid;
  assign w_count_after      = r_count + (w_push ? ONE_C : '0) - (w_pop ? ONE_C : '0);

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (redirect_valid) begin
          w_state_next = ST_REQ;
        end else if (!halt && (r_count < DEPTH_C)) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        // An unaccepted request simply retargets to the new fetch_pc.
        if (mem_req_ready) begin
          w_state_next = redirect_valid ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          w_state_next = mem_rsp_valid ? ST_REQ : ST_DRAIN;
        end else if (mem_rsp_valid) begin
          // Only issue again if the next response is guaranteed a slot.
          w_state_next = (!halt && (w_count_after < DEPTH_C)) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // The in-flight response is thrown away; the buffer is empty here.
        if (mem_rsp_valid) begin
          w_state_next = (redirect_valid || !halt) ? ST_REQ : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Control state, PCs and FIFO pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC & ~64'h3;
      r_req_pc   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_next;

      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_aligned;
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 64'd4;
      end

      if (w_accept) begin
        r_req_pc <= r_fetch_pc;
      end

      if (redirect_valid) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= w_count_after;
      end
    end
  end

  // Buffer storage; contents are only visible while the entry is counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr]  <= r_req_pc;
      r_mem_instr[r_wr_ptr] <= mem_rsp_data;
      r_mem_fault[r_wr_ptr] <= mem_rsp_err;
    end
  end

  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_req_addr  = (r_state == ST_REQ) ? r_fetch_pc : '0;

  assign out_valid = w_out_valid;
  assign out_addr  = w_out_valid ? r_mem_addr[r_rd_ptr]  : '0;
  assign out_instr = w_out_valid ? r_mem_instr[r_rd_ptr] : '0;
  assign out_fault = w_out_valid ? r_mem_fault[r_rd_ptr] : 1'b0;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic [63:0] out_addr;
  logic [31:0] out_instr;
  logic        out_fault;
  logic        out_ready;

  instr_fetch #(.RESET_PC(64'h1000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .out_valid(out_valid), .out_addr(out_addr),
    .out_instr(out_instr), .out_fault(out_fault), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Zero-wait memory model: always ready, answers one cycle after acceptance.
  logic        hold;        // withhold the pending response
  logic        pend;
  logic [63:0] pend_addr;
  logic [63:0] err_addr;
  logic        tick_acc;
  logic [63:0] tick_acc_addr;
  logic [63:0] req_log [64];
  int          n_req;
  logic [63:0] dlv_addr [64];
  logic        dlv_fault [64];
  int          n_dlv;

  task automatic tick();
    mem_req_ready = 1'b1;
    mem_rsp_valid = hold ? 1'b0 : pend;
    mem_rsp_err   = mem_rsp_valid && (pend_addr == err_addr);
    mem_rsp_data  = mem_rsp_valid ? 32'h0000_0013 : 32'h0;
    tick_acc      = mem_req_valid && mem_req_ready;
    tick_acc_addr = mem_req_addr;
    if (tick_acc && n_req < 64) begin
      req_log[n_req] = mem_req_addr;
      n_req++;
    end
    if (out_valid && out_ready && !redirect_valid && n_dlv < 64) begin
      dlv_addr[n_dlv]  = out_addr;
      dlv_fault[n_dlv] = out_fault;
      n_dlv++;
    end
    @(posedge clk);
    #1;
    if (tick_acc) begin
      pend      = 1'b1;
      pend_addr = tick_acc_addr;
    end else if (mem_rsp_valid) begin
      pend = 1'b0;
    end
  endtask

  task automatic run_until_acc(input logic [63:0] target, output logic found);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (tick_acc && tick_acc_addr == target) found = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b0;
    hold = 1'b0; pend = 1'b0; pend_addr = '0; err_addr = '1;
    n_req = 0; n_dlv = 0; tick_acc = 1'b0; tick_acc_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    do_reset();
    reset = 1'b1;
    out_ready = 1'b1; mem_rsp_valid = 1'b1; mem_req_ready = 1'b1; redirect_valid = 1'b1;
    redirect_pc = 64'h5554;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
    tests_run++;
    if (mem_req_addr !== 64'h0) begin tests_failed++; $display("FAIL reset_req_addr got=%h exp=0", mem_req_addr); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests_run++;
    if (out_addr !== 64'h0 || out_instr !== 32'h0 || out_fault !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_data got=%h/%h/%b exp=0/0/0", out_addr, out_instr, out_fault);
    end
    do_reset();
  endtask

  task automatic test_startup();
    $display("[TB] test_startup");
    do_reset();
    tests_run++;
    if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL start_idle got=%b exp=0", mem_req_valid); end
    out_ready = 1'b1;
    tick(); // cycle 0
    tests_run++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1000) begin
      tests_failed++; $display("FAIL start_c0_req got=%b/%h exp=1/1000", mem_req_valid, mem_req_addr);
    end
    tick(); // cycle 1
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL start_c1_out_valid got=%b exp=0", out_valid); end
    tick(); // cycle 2
    tests_run++;
    if (out_valid !== 1'b1 || out_addr !== 64'h1000 || out_instr !== 32'h13) begin
      tests_failed++; $display("FAIL start_c2_out got=%b/%h/%h exp=1/1000/13", out_valid, out_addr, out_instr);
    end
    tests_run++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1004) begin
      tests_failed++; $display("FAIL start_c2_req got=%b/%h exp=1/1004", mem_req_valid, mem_req_addr);
    end
    tick(); // cycle 3
    tick(); // cycle 4
    tests_run++;
    if (out_valid !== 1'b1 || out_addr !== 64'h1004) begin
      tests_failed++; $display("FAIL start_c4_out got=%b/%h exp=1/1004", out_valid, out_addr);
    end
  endtask

  task automatic test_backpressure();
    logic found;
    $display("[TB] test_backpressure");
    do_reset();
    out_ready = 1'b0;
    run_until_acc(64'h1004, found);
    tests_run++;
    if (!found) begin tests_failed++; $display("FAIL bp_second_req got=timeout exp=1004"); end
    repeat (6) tick();
    tests_run++;
    if (n_req !== 2) begin tests_failed++; $display("FAIL bp_req_count got=%0d exp=2", n_req); end
    tests_run++;
    if (req_log[0] !== 64'h1000 || req_log[1] !== 64'h1004) begin
      tests_failed++; $display("FAIL bp_req_addrs got=%h,%h exp=1000,1004", req_log[0], req_log[1]);
    end
    tests_run++;
    if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_idle got=%b exp=0", mem_req_valid); end
    tests_run++;
    if (out_valid !== 1'b1 || out_addr !== 64'h1000) begin
      tests_failed++; $display("FAIL bp_head_stable got=%b/%h exp=1/1000", out_valid, out_addr);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20 && n_dlv < 3; i++) tick();
    tests_run++;
    if (n_dlv < 3) begin
      tests_failed++; $display("FAIL bp_drain_count got=%0d exp=3", n_dlv);
    end else if (dlv_addr[0] !== 64'h1000 || dlv_addr[1] !== 64'h1004 || dlv_addr[2] !== 64'h1008) begin
      tests_failed++; $display("FAIL bp_drain_order got=%h,%h,%h exp=1000,1004,1008", dlv_addr[0], dlv_addr[1], dlv_addr[2]);
    end
  endtask

  task automatic test_redirect_wait();
    logic found;
    $display("[TB] test_redirect_wait");
    do_reset();
    out_ready = 1'b0;
    run_until_acc(64'h1004, found);
    repeat (2) tick();   // buffer full, IDLE
    out_ready = 1'b1;
    tick();              // pop 0x1000
    out_ready = 1'b0;
    hold = 1'b1;
    run_until_acc(64'h1008, found);
    tests_run++;
    if (!found || out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL rw_setup got=%b/%b exp=1/1", found, out_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'h2002;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_flush got=%b exp=0", out_valid); end
    hold = 1'b0;
    tick();              // stale 0x1008 response arrives in DRAIN
    tests_run++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h2000) begin
      tests_failed++; $display("FAIL rw_new_req got=%b/%h exp=1/2000", mem_req_valid, mem_req_addr);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_stale_drop got=%b exp=0", out_valid); end
    repeat (2) tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_addr !== 64'h2000) begin
      tests_failed++; $display("FAIL rw_first_new got=%b/%h exp=1/2000", out_valid, out_addr);
    end
  endtask

  task automatic test_simultaneous();
    logic found;
    int   dlv_before;
    $display("[TB] test_simultaneous");
    do_reset();
    out_ready = 1'b0;
    run_until_acc(64'h1004, found);   // 0x1000 buffered, 0x1004 response due
    tests_run++;
    if (!found || out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL sim_setup got=%b/%b exp=1/1", found, out_valid);
    end
    dlv_before = n_dlv;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h3000;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL sim_empty got=%b exp=0", out_valid); end
    tests_run++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h3000) begin
      tests_failed++; $display("FAIL sim_req got=%b/%h exp=1/3000", mem_req_valid, mem_req_addr);
    end
    repeat (2) tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_addr !== 64'h3000 || n_dlv !== dlv_before) begin
      tests_failed++; $display("FAIL sim_no_push got=%b/%h/%0d exp=1/3000/%0d", out_valid, out_addr, n_dlv, dlv_before);
    end
  endtask

  task automatic test_fault_halt();
    logic found;
    $display("[TB] test_fault_halt");
    do_reset();
    err_addr = 64'h1004;
    out_ready = 1'b1;
    run_until_acc(64'h1008, found);
    tests_run++;
    if (!found) begin tests_failed++; $display("FAIL fh_setup got=timeout exp=1008"); end
    halt = 1'b1;
    repeat (8) tick();
    tests_run++;
    if (n_req !== 3 || mem_req_valid !== 1'b0) begin
      tests_failed++; $display("FAIL fh_halt got=%0d/%b exp=3/0", n_req, mem_req_valid);
    end
    tests_run++;
    if (n_dlv !== 3) begin
      tests_failed++; $display("FAIL fh_count got=%0d exp=3", n_dlv);
    end else if (dlv_addr[2] !== 64'h1008) begin
      tests_failed++; $display("FAIL fh_pending_word got=%h exp=1008", dlv_addr[2]);
    end
    tests_run++;
    if (dlv_fault[0] !== 1'b0 || dlv_fault[1] !== 1'b1 || dlv_fault[2] !== 1'b0) begin
      tests_failed++; $display("FAIL fh_fault got=%b%b%b exp=010", dlv_fault[0], dlv_fault[1], dlv_fault[2]);
    end
    halt = 1'b0;
  endtask

  task automatic test_async_reset();
    logic found;
    $display("[TB] test_async_reset");
    do_reset();
    out_ready = 1'b0;
    run_until_acc(64'h1004, found);   // in WAIT with 0x1000 buffered
    tests_run++;
    if (!found || out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL ar_setup got=%b/%b exp=1/1", found, out_valid);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_addr !== 64'h0 || out_instr !== 32'h0) begin
      tests_failed++; $display("FAIL ar_out_async got=%b/%h/%h exp=0/0/0", out_valid, out_addr, out_instr);
    end
    tests_run++;
    if (mem_req_valid !== 1'b0 || mem_req_addr !== 64'h0) begin
      tests_failed++; $display("FAIL ar_req_async got=%b/%h exp=0/0", mem_req_valid, mem_req_addr);
    end
    reset = 1'b0;
    n_req = 0;
    tick();                           // late 0x1004 response arrives in IDLE
    tests_run++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1000 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL ar_late_ignored got=%b/%h/%b exp=1/1000/0", mem_req_valid, mem_req_addr, out_valid);
    end
    repeat (2) tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_addr !== 64'h1000) begin
      tests_failed++; $display("FAIL ar_restart got=%b/%h exp=1/1000", out_valid, out_addr);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect_wait();
    test_simultaneous();
    test_fault_halt();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
